// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan stage. Holds an N-digit packed
// BCD/hex value and presents one nibble at a time to the downstream
// decoder. Each digit drives its active-low anode. A dark gap comes before
// every digit. New values wait in a shadow register and are applied only
// at a frame wrap, so a frame never mixes old and new digits.
module seg_scan_driver #(
    parameter int N_DIGITS     = 2,
    parameter int DIGIT_CYCLES = 50000,
    parameter int GAP_CYCLES   = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    lzs_en,
    output logic [3:0]              bcd_out,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IW   = $clog2(N_DIGITS);
    localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    // Counts cycles already spent in the current state; the state ends when
    // the count reaches its length minus one.
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   active_q, active_d;
    logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    fd_q, fd_d;

    logic [3:0]              act_nib [N_DIGITS];
    logic [3:0]              sh_nib  [N_DIGITS];
    logic [N_DIGITS-1:0]     dark_vec;

    // Per-digit nibble views and dark decision (blanking or leading zero).
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign act_nib[gi] = active_q[4*gi +: 4];
        assign sh_nib[gi]  = shadow_q[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            // The least significant digit always shows, even when zero.
            assign dark_vec[gi] = blank_in[gi];
        end else begin : g_upper
            logic hi_zero;
            assign hi_zero      = (active_q[4*N_DIGITS-1:4*gi] == '0);
            assign dark_vec[gi] = blank_in[gi] | (lzs_en & hi_zero);
        end
    end

    // Next-state logic: gap/on sequencing, digit advance and frame-wrap update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 1'b1;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        bcd_d     = bcd_q;
        an_d      = an_q;
        fd_d      = 1'b0;

        if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    // Dark-ness is frozen here for the whole on period.
                    an_d    = dark_vec[idx_q] ? '1 : ~(N_DIGITS'(1) << idx_q);
                end
            end
            ST_ON: begin
                if (cnt_q == DIGIT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    an_d    = '1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        fd_d  = 1'b1;
                        if (pending_q) begin
                            active_d = shadow_q;
                            bcd_d    = sh_nib[0];
                        end else begin
                            bcd_d    = act_nib[0];
                        end
                        // A load landing on the wrap edge stays pending.
                        if (!load) begin
                            pending_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        bcd_d = act_nib[idx_q + 1'b1];
                    end
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
                an_d    = '1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously to a dark display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_GAP;
            idx_q     <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            bcd_q     <= '0;
            an_q      <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign pending    = pending_q;

endmodule
